// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard bundle: decode/EX/MEM hazard sources in, pipeline sequencing controls out.
interface id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       id_op;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [4:0]       ex_dst;
  logic             mem_memread;
  logic [4:0]       mem_dst;
  logic             dmem_ready;
  logic             branch_taken;
  logic             PCWrite;
  logic             freeze;
  logic             ctrl_mux;
  logic             flush;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_op, id_rs, id_rt, ex_memread, ex_regwrite, ex_dst,
           mem_memread, mem_dst, dmem_ready, branch_taken,
    input  PCWrite, freeze, ctrl_mux, flush, stall_cycles
  );

  modport slave (
    input  id_op, id_rs, id_rt, ex_memread, ex_regwrite, ex_dst,
           mem_memread, mem_dst, dmem_ready, branch_taken,
    output PCWrite, freeze, ctrl_mux, flush, stall_cycles
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage sequencer: zero-latency load-use / branch-operand stalls, data-memory wait freeze,
// taken-branch flush, and a saturating stall-cycle counter.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  id_hazard_ctrl_if.slave bus
);
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {RUN, STALL, MEMWAIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       left;
  logic [1:0]       left_nxt;
  logic [CNT_W-1:0] cnt;

  logic       is_beq;
  logic       ex_hit;
  logic       mem_hit;
  logic       lu;
  logic       br_ex;
  logic       br_mem;
  logic       mw;
  logic       any_haz;
  logic [1:0] need;

  logic pc_write;
  logic freeze;
  logic ctrl_mux;
  logic flush;

  // r0 is hardwired zero, so it can never be a true dependency
  assign ex_hit  = (bus.ex_dst  != 5'd0) && ((bus.ex_dst  == bus.id_rs) || (bus.ex_dst  == bus.id_rt));
  assign mem_hit = (bus.mem_dst != 5'd0) && ((bus.mem_dst == bus.id_rs) || (bus.mem_dst == bus.id_rt));

  assign is_beq  = (bus.id_op == OP_BEQ);
  assign lu      = bus.ex_memread && ex_hit;
  assign br_ex   = is_beq && bus.ex_regwrite && !bus.ex_memread && ex_hit;
  assign br_mem  = is_beq && bus.mem_memread && mem_hit;
  assign mw      = bus.mem_memread && !bus.dmem_ready;
  assign any_haz = lu || br_ex || br_mem || mw;

  // A beq behind a load must wait for the value to clear MEM, hence two cycles
  always_comb begin
    need = 2'd0;
    if (br_ex || br_mem) need = 2'd1;
    if (lu)              need = is_beq ? 2'd2 : 2'd1;
  end

  always_comb begin
    state_nxt = state;
    left_nxt  = left;
    unique case (state)
      STALL: begin
        if (mw) begin
          state_nxt = MEMWAIT;
        end else begin
          left_nxt  = left - 2'd1;
          state_nxt = (left == 2'd1) ? RUN : STALL;
        end
      end
      MEMWAIT: begin
        if (bus.dmem_ready) state_nxt = (left != 2'd0) ? STALL : RUN;
      end
      default: begin
        if (mw) begin
          state_nxt = MEMWAIT;
        end else if (need != 2'd0) begin
          left_nxt  = need - 2'd1;
          state_nxt = (need != 2'd1) ? STALL : RUN;
        end
      end
    endcase
  end

  // In MEMWAIT ID/EX holds too, so the decoded control passes rather than a bubble
  always_comb begin
    pc_write = 1'b1;
    freeze   = 1'b0;
    ctrl_mux = 1'b1;
    flush    = 1'b0;
    unique case (state)
      STALL: begin
        pc_write = 1'b0;
        freeze   = 1'b1;
        ctrl_mux = 1'b0;
      end
      MEMWAIT: begin
        pc_write = 1'b0;
        freeze   = 1'b1;
      end
      default: begin
        if (any_haz) begin
          pc_write = 1'b0;
          freeze   = 1'b1;
          ctrl_mux = 1'b0;
        end else begin
          flush = bus.branch_taken;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      left  <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      left  <= left_nxt;
      if (!pc_write && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.PCWrite      = pc_write;
  assign bus.freeze       = freeze;
  assign bus.ctrl_mux     = ctrl_mux;
  assign bus.flush        = flush;
  assign bus.stall_cycles = cnt;
endmodule
